// File: rtl/wb_arbiter.sv
// wb_arbiter: two-producer write-back arbiter feeding one regfile write port.
// Define WB_PENDING_EN to build the pending-write scoreboard.

module wb_arbiter_q #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    input  logic [3:0]  stamp,
    input  logic        pop,
    output logic        ready,
    output logic        nonempty,
    output logic [4:0]  head_addr,
    output logic [31:0] head_data,
    output logic [3:0]  head_stamp
`ifdef WB_PENDING_EN
    ,
    output logic [31:0] mask
`endif
);
    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    q_addr  [DEPTH];
    logic [31:0]   q_data  [DEPTH];
    logic [3:0]    q_stamp [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [AW:0]   cnt;

    assign ready      = rst && (cnt < FULL);
    assign nonempty   = (cnt != '0);
    assign head_addr  = q_addr[rd];
    assign head_data  = q_data[rd];
    assign head_stamp = q_stamp[rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop)  rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Payload needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr]  <= addr;
            q_data[wr]  <= data;
            q_stamp[wr] <= stamp;
        end
    end

`ifdef WB_PENDING_EN
    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            if (pop)  vld[rd] <= 1'b0;
            if (push) vld[wr] <= 1'b1;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) mask[q_addr[i]] = 1'b1;
        end
    end
`endif
endmodule

module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_addr,
    input  logic [31:0] ex_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        we,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    output logic [31:0] pending
);
    logic [3:0]  stamp;
    logic        ex_push, ld_push;
    logic        ex_ne, ld_ne;
    logic        ex_win, ld_win;
    logic [4:0]  ex_haddr, ld_haddr;
    logic [31:0] ex_hdata, ld_hdata;
    logic [3:0]  ex_hstamp, ld_hstamp;
    logic [3:0]  age;

    // Writes to x0 are handshaken but never enter a queue.
    assign ex_push = ex_valid && ex_ready && (ex_addr != 5'd0);
    assign ld_push = ld_valid && ld_ready && (ld_addr != 5'd0);

    assign age    = ex_hstamp - ld_hstamp;
    assign ex_win = ex_ne && (!ld_ne || age == 4'd0 || age[3]);
    assign ld_win = ld_ne && !ex_win;

`ifdef WB_PENDING_EN
    logic [31:0] ex_mask, ld_mask;
`endif

    wb_arbiter_q #(.DEPTH(DEPTH)) u_exq (
        .clk        (clk),
        .rst        (rst),
        .push       (ex_push),
        .addr       (ex_addr),
        .data       (ex_data),
        .stamp      (stamp),
        .pop        (ex_win),
        .ready      (ex_ready),
        .nonempty   (ex_ne),
        .head_addr  (ex_haddr),
        .head_data  (ex_hdata),
        .head_stamp (ex_hstamp)
`ifdef WB_PENDING_EN
        ,
        .mask       (ex_mask)
`endif
    );

    wb_arbiter_q #(.DEPTH(DEPTH)) u_ldq (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_push),
        .addr       (ld_addr),
        .data       (ld_data),
        .stamp      (stamp),
        .pop        (ld_win),
        .ready      (ld_ready),
        .nonempty   (ld_ne),
        .head_addr  (ld_haddr),
        .head_data  (ld_hdata),
        .head_stamp (ld_hstamp)
`ifdef WB_PENDING_EN
        ,
        .mask       (ld_mask)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stamp <= 4'd0;
        end else if (ex_push || ld_push) begin
            stamp <= stamp + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we        <= 1'b0;
            WriteAddr <= 5'd0;
            WriteData <= 32'd0;
        end else begin
            unique case (1'b1)
                ex_win: begin
                    we        <= 1'b1;
                    WriteAddr <= ex_haddr;
                    WriteData <= ex_hdata;
                end
                ld_win: begin
                    we        <= 1'b1;
                    WriteAddr <= ld_haddr;
                    WriteData <= ld_hdata;
                end
                default: we <= 1'b0;
            endcase
        end
    end

`ifdef WB_PENDING_EN
    logic [31:0] stage_mask;

    always_comb begin
        stage_mask = '0;
        if (we) stage_mask[WriteAddr] = 1'b1;
    end

    assign pending = (ex_mask | ld_mask | stage_mask) & ~32'h1;
`else
    assign pending = 32'h0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (DEPTH = 2).

module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_addr = 5'd0;
    logic [31:0] ex_data = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic        we;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [31:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .we        (we),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .pending   (pending)
    );

    function automatic logic [31:0] pexp(input logic [31:0] m);
`ifdef WB_PENDING_EN
        return m;
`else
        return m & 32'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_valid = 1'b1;
        ex_addr = 5'd9;
        ex_data = 32'h1;
        step();
        step();
        n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ex_ready: got %b want 0", ex_ready); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
        n_cmp++; if (WriteAddr !== 5'd0) begin n_bad++; $display("FAIL rst_waddr: got %0d want 0", WriteAddr); end
        n_cmp++; if (WriteData !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", WriteData); end
        n_cmp++; if (pending !== 32'd0) begin n_bad++; $display("FAIL rst_pending: got %h want 0", pending); end
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ex_ready: got %b want 1", ex_ready); end
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ld_ready: got %b want 1", ld_ready); end
    endtask

    task automatic test_single();
        ex_valid = 1'b1;
        ex_addr = 5'd5;
        ex_data = 32'hDEADBEEF;
        step();
        ex_valid = 1'b0;
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL single_we0: got %b want 0", we); end
        n_cmp++; if (pending !== pexp(32'h20)) begin n_bad++; $display("FAIL single_pend_q: got %h want %h", pending, pexp(32'h20)); end
        step();
        n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL single_we1: got %b want 1", we); end
        n_cmp++; if (WriteAddr !== 5'd5) begin n_bad++; $display("FAIL single_waddr: got %0d want 5", WriteAddr); end
        n_cmp++; if (WriteData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_wdata: got %h want deadbeef", WriteData); end
        n_cmp++; if (pending !== pexp(32'h20)) begin n_bad++; $display("FAIL single_pend_s: got %h want %h", pending, pexp(32'h20)); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL single_we_end: got %b want 0", we); end
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL single_pend_end: got %h want 0", pending); end
        n_cmp++; if (WriteData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_hold: got %h want deadbeef", WriteData); end
    endtask

    task automatic test_same_reg();
        ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'h1;
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h2;
        step();
        ex_valid = 1'b0;
        ld_valid = 1'b0;
        n_cmp++; if (pending !== pexp(32'h80)) begin n_bad++; $display("FAIL same_pend: got %h want %h", pending, pexp(32'h80)); end
        step();
        n_cmp++; if (we !== 1'b1 || WriteAddr !== 5'd7 || WriteData !== 32'h1) begin n_bad++; $display("FAIL same_first: got we=%b a=%0d d=%h want 1/7/1", we, WriteAddr, WriteData); end
        step();
        n_cmp++; if (we !== 1'b1 || WriteAddr !== 5'd7 || WriteData !== 32'h2) begin n_bad++; $display("FAIL same_second: got we=%b a=%0d d=%h want 1/7/2", we, WriteAddr, WriteData); end
        step();
        n_cmp++; if (we !== 1'b0 || WriteData !== 32'h2) begin n_bad++; $display("FAIL same_final: got we=%b d=%h want 0/2", we, WriteData); end
    endtask

    task automatic test_order();
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'hA;
        step();
        ld_valid = 1'b0;
        ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 32'hB;
        step();
        ex_valid = 1'b0;
        n_cmp++; if (we !== 1'b1 || WriteData !== 32'hA) begin n_bad++; $display("FAIL order_first: got we=%b d=%h want 1/a", we, WriteData); end
        step();
        n_cmp++; if (we !== 1'b1 || WriteData !== 32'hB) begin n_bad++; $display("FAIL order_second: got we=%b d=%h want 1/b", we, WriteData); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL order_idle: got %b want 0", we); end
    endtask

    task automatic test_backpressure();
        logic [4:0]  ea [4];
        logic [31:0] ed [4];
        ea[0] = 5'd11; ed[0] = 32'h101;
        ea[1] = 5'd21; ed[1] = 32'h201;
        ea[2] = 5'd12; ed[2] = 32'h102;
        ea[3] = 5'd22; ed[3] = 32'h202;
        ex_valid = 1'b1; ex_addr = 5'd10; ex_data = 32'h100;
        ld_valid = 1'b1; ld_addr = 5'd20; ld_data = 32'h200;
        n_cmp++; if (ex_ready !== 1'b1 || ld_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy0: got ex=%b ld=%b want 1/1", ex_ready, ld_ready); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL bp_we0: got %b want 0", we); end
        ex_addr = 5'd11; ex_data = 32'h101;
        ld_addr = 5'd21; ld_data = 32'h201;
        n_cmp++; if (ex_ready !== 1'b1 || ld_ready !== 1'b1) begin n_bad++; $display("FAIL bp_rdy1: got ex=%b ld=%b want 1/1", ex_ready, ld_ready); end
        step();
        n_cmp++; if (we !== 1'b1 || WriteAddr !== 5'd10 || WriteData !== 32'h100) begin n_bad++; $display("FAIL bp_e1: got we=%b a=%0d d=%h want 1/10/100", we, WriteAddr, WriteData); end
        ex_addr = 5'd12; ex_data = 32'h102;
        ld_addr = 5'd22; ld_data = 32'h202;
        n_cmp++; if (ld_ready !== 1'b0 || ex_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ld_full: got ex=%b ld=%b want 1/0", ex_ready, ld_ready); end
        step();
        ex_valid = 1'b0;
        n_cmp++; if (we !== 1'b1 || WriteAddr !== 5'd20 || WriteData !== 32'h200) begin n_bad++; $display("FAIL bp_l1: got we=%b a=%0d d=%h want 1/20/200", we, WriteAddr, WriteData); end
        n_cmp++; if (pending !== pexp(32'h00301800)) begin n_bad++; $display("FAIL bp_pend: got %h want %h", pending, pexp(32'h00301800)); end
        n_cmp++; if (ld_ready !== 1'b1 || ex_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy3: got ex=%b ld=%b want 0/1", ex_ready, ld_ready); end
        step();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (we !== 1'b1 || WriteAddr !== ea[i] || WriteData !== ed[i]) begin
                n_bad++;
                $display("FAIL bp_out%0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, we, WriteAddr, WriteData, ea[i], ed[i]);
            end
            step();
        end
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", we); end
        n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL bp_pend_end: got %h want 0", pending); end
    endtask

    task automatic test_x0();
        ex_valid = 1'b1; ex_addr = 5'd0; ex_data = 32'hFFFFFFFF;
        n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", ex_ready); end
        step();
        ex_valid = 1'b0;
        n_cmp++; if (we !== 1'b0 || pending !== 32'h0) begin n_bad++; $display("FAIL x0_q: got we=%b p=%h want 0/0", we, pending); end
        step();
        n_cmp++; if (we !== 1'b0 || WriteData !== 32'h202) begin n_bad++; $display("FAIL x0_stage: got we=%b d=%h want 0/202", we, WriteData); end
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL x0_late: got %b want 0", we); end
    endtask

    task automatic test_mid_reset();
        ex_valid = 1'b1; ex_addr = 5'd4; ex_data = 32'h44;
        ld_valid = 1'b1; ld_addr = 5'd6; ld_data = 32'h66;
        step();
        ex_valid = 1'b0;
        ld_valid = 1'b0;
        step();
        n_cmp++; if (we !== 1'b1 || WriteAddr !== 5'd4) begin n_bad++; $display("FAIL mr_pre: got we=%b a=%0d want 1/4", we, WriteAddr); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (we !== 1'b0 || WriteAddr !== 5'd0 || WriteData !== 32'd0) begin n_bad++; $display("FAIL mr_async: got we=%b a=%0d d=%h want 0/0/0", we, WriteAddr, WriteData); end
        n_cmp++; if (pending !== 32'h0 || ex_ready !== 1'b0) begin n_bad++; $display("FAIL mr_state: got p=%h rdy=%b want 0/0", pending, ex_ready); end
        #1;
        rst = 1'b1;
        step();
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL mr_drop1: got %b want 0", we); end
        step();
        n_cmp++; if (we !== 1'b0 || pending !== 32'h0) begin n_bad++; $display("FAIL mr_drop2: got we=%b p=%h want 0/0", we, pending); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_same_reg();
        test_order();
        test_backpressure();
        test_x0();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
